// File: rtl/mac_stream_tx.sv
// mac_stream_tx: operand-pair stream transmitter feeding the mac slave port.
//
// The control side writes data/weight pairs into a circular show-ahead FIFO.
// A start request with 1 <= len <= level launches a packet of len beats on a
// valid/ready master stream; the final beat carries tlast_m and done pulses
// for one cycle after the last handshake. Writes are accepted in every state
// so the buffer can be refilled while a packet is in flight.
//
// Optional build macro: MAC_TX_LEN_CHK_EN adds the err output, a one-cycle
// pulse (registered) for a rejected start in IDLE or a write while full.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en, wr_data, wr_weight  pair write (ignored while full)
//   full, level                buffer status
//   start, len                 packet request (len sampled on acceptance)
//   busy                       high while sending
//   tvalid_m, tready_m         master stream handshake
//   tdata_m, weight_m, tlast_m head pair and last-beat flag (zero when idle)
//   done                       one-cycle pulse after the last beat
//   err                        (MAC_TX_LEN_CHK_EN only) rejected start/write
module mac_stream_tx #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_weight,
  output logic             full,
  output logic [CW-1:0]    level,
  input  logic             start,
  input  logic [CW-1:0]    len,
  output logic             busy,
  output logic             tvalid_m,
  input  logic             tready_m,
  output logic [WIDTH-1:0] tdata_m,
  output logic [WIDTH-1:0] weight_m,
  output logic             tlast_m,
  output logic             done
`ifdef MAC_TX_LEN_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LVL_ONE  = CW'(1);
  localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] data_mem   [DEPTH];
  logic [WIDTH-1:0] weight_mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] remaining_q, remaining_d;

  logic send;
  logic full_w;
  logic wr_fire;
  logic pop;
  logic start_ok;

  always_comb begin
    send     = (state_q == S_SEND);
    full_w   = (level_q == LVL_FULL);
    wr_fire  = wr_en && !full_w;
    pop      = send && tready_m;
    // len is compared against the level before any same-cycle write.
    start_ok = start && (len != '0) && (len <= level_q);

    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_SEND;
          remaining_d = len;
        end
      end
      S_SEND: begin
        if (tready_m) begin
          remaining_d = remaining_q - LVL_ONE;
          if (remaining_q == LVL_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pointers are AW bits wide, so DEPTH being a power of two makes the
    // increment wrap modulo DEPTH for free.
    wr_ptr_d = wr_fire ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    level_d = level_q;
    if (wr_fire && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!wr_fire && pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      remaining_q <= remaining_d;
    end
  end

  // Storage carries no reset: an empty buffer is defined by the pointers
  // and level alone.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      data_mem[wr_ptr_q]   <= wr_data;
      weight_mem[wr_ptr_q] <= wr_weight;
    end
  end

  assign full     = full_w;
  assign level    = level_q;
  assign busy     = send;
  assign tvalid_m = send;
  // Show-ahead head; forced to zero outside SEND so idle beats are clean.
  assign tdata_m  = send ? data_mem[rd_ptr_q]   : '0;
  assign weight_m = send ? weight_mem[rd_ptr_q] : '0;
  assign tlast_m  = send && (remaining_q == LVL_ONE);
  assign done     = (state_q == S_DONE);

`ifdef MAC_TX_LEN_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = ((state_q == S_IDLE) && start && !start_ok) || (wr_en && full_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mac_stream_tx.sv
// Testbench for mac_stream_tx: table-driven packet vectors, hand-written
// corner sequences (full buffer with overlapping refill, reset mid-packet)
// and a randomized phase, all checked every cycle against a queue-based
// reference model of the buffer and packet rules.
module tb_mac_stream_tx;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_weight;
  logic             full;
  logic [CW-1:0]    level;
  logic             start;
  logic [CW-1:0]    len;
  logic             busy;
  logic             tvalid_m;
  logic             tready_m;
  logic [WIDTH-1:0] tdata_m;
  logic [WIDTH-1:0] weight_m;
  logic             tlast_m;
  logic             done;
`ifdef MAC_TX_LEN_CHK_EN
  logic             err;
`endif

  mac_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_weight (wr_weight),
    .full      (full),
    .level     (level),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .tvalid_m  (tvalid_m),
    .tready_m  (tready_m),
    .tdata_m   (tdata_m),
    .weight_m  (weight_m),
    .tlast_m   (tlast_m),
    .done      (done)
`ifdef MAC_TX_LEN_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of pairs; a packet in flight is
  // described by how many beats are still owed.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] w;
  } pair_t;

  pair_t m_q[$];
  bit    m_valid = 0;
  int    m_left  = 0;
  bit    m_done  = 0;
  bit    m_err   = 0;

  // Observed DUT activity, used by the directed tests.
  int     hs_total   = 0;
  int     done_total = 0;
  longint sum_total  = 0;

  // Compare DUT outputs with the model, then advance the model to what the
  // next rising edge must produce. Called at the falling edge.
  task automatic monitor();
    int sz;
    bit idle, wr, acc, nd, en;
    if (!rst_n) begin
      check("rst_tvalid", 64'(tvalid_m), 64'(0));
      check("rst_tdata",  64'(tdata_m),  64'(0));
      check("rst_weight", 64'(weight_m), 64'(0));
      check("rst_tlast",  64'(tlast_m),  64'(0));
      check("rst_busy",   64'(busy),     64'(0));
      check("rst_done",   64'(done),     64'(0));
      check("rst_level",  64'(level),    64'(0));
      check("rst_full",   64'(full),     64'(0));
`ifdef MAC_TX_LEN_CHK_EN
      check("rst_err",    64'(err),      64'(0));
`endif
      m_q.delete();
      m_valid = 0;
      m_left  = 0;
      m_done  = 0;
      m_err   = 0;
      return;
    end
    sz = m_q.size();
    check("tvalid", 64'(tvalid_m), 64'(m_valid));
    check("busy",   64'(busy),     64'(m_valid));
    check("level",  64'(level),    64'(sz));
    check("full",   64'(full),     64'(sz == DEPTH));
    check("done",   64'(done),     64'(m_done));
    if (m_valid && sz > 0) begin
      check("tdata",  64'(tdata_m),  64'(m_q[0].d));
      check("weight", 64'(weight_m), 64'(m_q[0].w));
      check("tlast",  64'(tlast_m),  64'(m_left == 1));
    end else begin
      check("tdata_idle",  64'(tdata_m),  64'(0));
      check("weight_idle", 64'(weight_m), 64'(0));
      check("tlast_idle",  64'(tlast_m),  64'(0));
    end
`ifdef MAC_TX_LEN_CHK_EN
    check("err", 64'(err), 64'(m_err));
`endif
    if (tvalid_m && tready_m) begin
      hs_total++;
      sum_total += longint'(64'(tdata_m) * 64'(weight_m));
    end
    if (done) done_total++;

    idle = !m_valid && !m_done;
    wr   = wr_en && (sz < DEPTH);
    acc  = idle && start && (len != 0) && (int'(len) <= sz);
    en   = (idle && start && !acc) || (wr_en && sz == DEPTH);
    nd   = 0;
    if (m_valid && tready_m) begin
      void'(m_q.pop_front());
      m_left--;
      if (m_left == 0) begin
        m_valid = 0;
        nd = 1;
      end
    end
    if (wr) m_q.push_back('{d: wr_data, w: wr_weight});
    if (acc) begin
      m_valid = 1;
      m_left  = int'(len);
    end
    m_done = nd;
    m_err  = en;
  endtask

  // One clock cycle: check at the falling edge, then return just after the
  // next rising edge so new stimulus is applied away from the edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         nwr;
    int         base;
    int         plen;
    logic [3:0] pat;
    int         exp_beats;
    int         exp_done;
    int         exp_level;
    int         exp_cyc;
    longint     exp_sum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hs0, d0, c, n;
    longint s0;
    bit fin;

    // Packet vectors; pairs are data=base+k, weight=base+k+1.
    vecs[0] = '{nwr:20, base:0,   plen:20, pat:4'b1111, exp_beats:20, exp_done:1, exp_level:0, exp_cyc:21, exp_sum:2660};
    vecs[1] = '{nwr:5,  base:100, plen:5,  pat:4'b1001, exp_beats:5,  exp_done:1, exp_level:0, exp_cyc:0,  exp_sum:52540};
    vecs[2] = '{nwr:3,  base:200, plen:4,  pat:4'b1111, exp_beats:0,  exp_done:0, exp_level:3, exp_cyc:0,  exp_sum:0};
    vecs[3] = '{nwr:0,  base:0,   plen:3,  pat:4'b0110, exp_beats:3,  exp_done:1, exp_level:0, exp_cyc:0,  exp_sum:121808};
    vecs[4] = '{nwr:2,  base:300, plen:0,  pat:4'b1111, exp_beats:0,  exp_done:0, exp_level:2, exp_cyc:0,  exp_sum:0};
    vecs[5] = '{nwr:0,  base:0,   plen:2,  pat:4'b1011, exp_beats:2,  exp_done:1, exp_level:0, exp_cyc:0,  exp_sum:181202};

    rst_n = 1'b0; wr_en = 0; wr_data = '0; wr_weight = '0;
    start = 0; len = '0; tready_m = 0;
    #1;
    tick();
    tick();
    check("reset_level",  64'(level),    64'(0));
    check("reset_full",   64'(full),     64'(0));
    check("reset_tvalid", 64'(tvalid_m), 64'(0));
    check("reset_done",   64'(done),     64'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven packets ----------------
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].nwr; k++) begin
        wr_en = 1; wr_data = WIDTH'(vecs[i].base + k); wr_weight = WIDTH'(vecs[i].base + k + 1);
        tick();
      end
      wr_en = 0;
      hs0 = hs_total; d0 = done_total; s0 = sum_total;
      start = 1; len = CW'(vecs[i].plen); tready_m = 0;
      tick();
      start = 0;
      c = 0;
      n = (vecs[i].exp_done != 0) ? 200 : 8;
      for (int t = 0; t < n; t++) begin
        tready_m = vecs[i].pat[c % 4];
        c++;
        tick();
        if (vecs[i].exp_done != 0 && done_total > d0) break;
      end
      tready_m = 0;
      if (vecs[i].exp_cyc != 0) check("vec_cycles", 64'(c), 64'(vecs[i].exp_cyc));
      tick();
      check("vec_beats", 64'(hs_total - hs0),   64'(vecs[i].exp_beats));
      check("vec_done",  64'(done_total - d0),  64'(vecs[i].exp_done));
      check("vec_level", 64'(level),            64'(vecs[i].exp_level));
      check("vec_sum",   64'(sum_total - s0),   64'(vecs[i].exp_sum));
      $display("vec %0d: len=%0d beats=%0d done=%0d level=%0d sum=%0d",
               i, vecs[i].plen, hs_total - hs0, done_total - d0, level, sum_total - s0);
    end

    // ---------------- fill to full, overlapping refill ----------------
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1; wr_data = $urandom; wr_weight = $urandom;
      tick();
    end
    check("fill_full",  64'(full),  64'(1));
    check("fill_level", 64'(level), 64'(DEPTH));
    wr_data = 32'hdead_beef; wr_weight = 32'hfeed_f00d;
    tick();
    check("drop_level", 64'(level), 64'(DEPTH));
    hs0 = hs_total; d0 = done_total;
    start = 1; len = CW'(DEPTH); tready_m = 1; wr_data = $urandom; wr_weight = $urandom;
    tick();
    start = 0;
    fin = 0;
    for (int t = 0; t < 100 && !fin; t++) begin
      wr_data = $urandom; wr_weight = $urandom;
      tick();
      fin = (done_total > d0);
    end
    wr_en = 0;
    check("wrap_beats", 64'(hs_total - hs0),  64'(DEPTH));
    check("wrap_done",  64'(done_total - d0), 64'(1));
    check("wrap_level", 64'(level),           64'(DEPTH));
    $display("wrap packet: beats=%0d level_after=%0d", hs_total - hs0, level);
    hs0 = hs_total; d0 = done_total;
    start = 1; len = CW'(DEPTH);
    tick();
    start = 0;
    fin = 0;
    for (int t = 0; t < 100 && !fin; t++) begin
      tick();
      fin = (done_total > d0);
    end
    check("drain_beats", 64'(hs_total - hs0), 64'(DEPTH));
    check("drain_level", 64'(level),          64'(0));
    $display("drain packet: beats=%0d level_after=%0d", hs_total - hs0, level);

    // ---------------- reset in the middle of a packet ----------------
    for (int k = 0; k < 10; k++) begin
      wr_en = 1; wr_data = WIDTH'(k + 7); wr_weight = WIDTH'(k + 9);
      tick();
    end
    wr_en = 0;
    hs0 = hs_total; d0 = done_total;
    start = 1; len = CW'(10); tready_m = 1;
    tick();
    start = 0;
    for (int t = 0; t < 50 && (hs_total - hs0) < 4; t++) tick();
    check("abort_hs", 64'(hs_total - hs0), 64'(4));
    #1 rst_n = 1'b0;
    #1;
    check("abort_tvalid", 64'(tvalid_m), 64'(0));
    check("abort_tdata",  64'(tdata_m),  64'(0));
    check("abort_weight", 64'(weight_m), 64'(0));
    check("abort_tlast",  64'(tlast_m),  64'(0));
    check("abort_busy",   64'(busy),     64'(0));
    check("abort_level",  64'(level),    64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    start = 1; len = CW'(1);
    tick();
    start = 0;
    for (int t = 0; t < 6; t++) tick();
    check("abort_done",     64'(done_total - d0), 64'(0));
    check("post_rst_beats", 64'(hs_total - hs0),  64'(4));
    check("post_rst_level", 64'(level),           64'(0));
    tready_m = 0;
    $display("abort: beats=%0d done=%0d level=%0d", hs_total - hs0, done_total - d0, level);

    // ---------------- randomized traffic ----------------
    d0 = done_total; hs0 = hs_total;
    for (int t = 0; t < 3000; t++) begin
      int hi;
      wr_en     = ($urandom_range(1) == 1);
      wr_data   = $urandom;
      wr_weight = $urandom;
      tready_m  = ($urandom_range(3) != 0);
      start     = ($urandom_range(7) == 0);
      hi        = m_q.size() + 2;
      if (hi > (1 << CW) - 1) hi = (1 << CW) - 1;
      len       = CW'($urandom_range(hi));
      tick();
    end
    wr_en = 0; start = 0; tready_m = 1;
    for (int t = 0; t < 80; t++) tick();
    $display("random: packets=%0d beats=%0d", done_total - d0, hs_total - hs0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
